univ_serializer: RTL and testbench

- Parallel-in, serial-out word transmitter that drives the serial data input of the team's universal shift register.
- Accepts an N-bit word over a valid/ready handshake and emits it one bit per enabled cycle, MSB-first or LSB-first, selectable per word.
- Produces first/last frame strobes and supports back-to-back words with no idle gap.

---
 rtl/univ_serializer.sv | 111 +++++++++++
 tb/tb_univ_serializer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_serializer.sv
// univ_serializer: parallel-in, serial-out word transmitter.
// Accepts an N-bit word over valid/ready and emits it one bit per enabled
// cycle, MSB-first or LSB-first (chosen per word), with first/last strobes.
// Words can follow each other back-to-back with no idle cycle between them.
module univ_serializer #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_data,
  input  logic         i_msb_first,
  input  logic         i_shift_en,
  output logic         o_sdata,
  output logic         o_svalid,
  output logic         o_first,
  output logic         o_last,
  output logic         o_busy
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  shreg, shreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dir, dir_nxt;
  logic          in_shift;
  logic          at_last;
  logic          accept;

  // State and datapath registers, cleared asynchronously so a reset abandons
  // any word in flight at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would chain them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: shreg is masked on o_sdata while IDLE, but clearing it keeps
      // the datapath free of X after reset at negligible cost.
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      dir   <= 1'b1;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
    end
  end

  // Next-state, handshake and serial output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    dir_nxt   = dir;

    in_shift = (state == SHIFT);
    at_last  = in_shift && (cnt == LAST);

    // Ready in IDLE, or in the last enabled bit slot so the next word can
    // load on the same edge the current one finishes. Forced low in reset.
    o_ready = !i_rst && (!in_shift || (at_last && i_shift_en));
    accept  = i_valid && o_ready;

    o_svalid = in_shift;
    o_busy   = in_shift;
    o_first  = in_shift && (cnt == '0);
    o_last   = at_last;
    o_sdata  = in_shift && (dir ? shreg[N-1] : shreg[0]);

    unique case (state)
      IDLE: begin
        // i_shift_en is irrelevant here; the first bit shows next cycle
        // regardless of it.
        if (accept) begin
          state_nxt = SHIFT;
          shreg_nxt = i_data;
          dir_nxt   = i_msb_first;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (i_shift_en) begin
          if (accept) begin
            // Back-to-back load wins over returning to IDLE.
            shreg_nxt = i_data;
            dir_nxt   = i_msb_first;
            cnt_nxt   = '0;
          end else if (at_last) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = cnt + CW'(1);
            shreg_nxt = dir ? (shreg << 1) : (shreg >> 1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_univ_serializer.sv
// Self-checking bench for univ_serializer (N=8). A behavioural model keeps
// each accepted word as a list of bits in emission order plus a position,
// and predicts the outputs cycle by cycle; directed scenarios also compare
// against literal bit sequences.
module tb_univ_serializer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic         ready;
  logic [N-1:0] data = '0;
  logic         msb_first = 1'b0;
  logic         shift_en = 1'b0;
  logic         sdata;
  logic         svalid;
  logic         first;
  logic         last;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // Behavioural model: word in flight as an emission-ordered bit list.
  bit   m_busy = 1'b0;
  logic m_bits [N];
  int   m_pos = 0;
  bit   m_acc = 1'b0;

  // Observed / predicted output vectors: {ready, svalid, busy, sdata, first, last}
  logic [5:0] obs;
  logic [5:0] expv;

  univ_serializer #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_data      (data),
    .i_msb_first (msb_first),
    .i_shift_en  (shift_en),
    .o_sdata     (sdata),
    .o_svalid    (svalid),
    .o_first     (first),
    .o_last      (last),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [5:0] model_out();
    logic r;
    logic b;
    r = !rst && (!m_busy || ((m_pos == N - 1) && shift_en));
    b = m_busy ? m_bits[m_pos] : 1'b0;
    return {r, m_busy, m_busy, b, m_busy && (m_pos == 0), m_busy && (m_pos == N - 1)};
  endfunction

  task automatic model_edge();
    logic [5:0] o;
    o = model_out();
    m_acc = valid && o[5];
    if (m_busy && shift_en) begin
      if (m_pos == N - 1) m_busy = 1'b0;
      else m_pos++;
    end
    if (m_acc) begin
      for (int k = 0; k < N; k++) m_bits[k] = msb_first ? data[N-1-k] : data[k];
      m_pos  = 0;
      m_busy = 1'b1;
    end
  endtask

  function automatic logic [5:0] dut_out();
    return {ready, svalid, busy, sdata, first, last};
  endfunction

  // Drive one cycle's inputs, sample outputs mid-cycle, advance model and DUT.
  task automatic cycle(input logic v, input logic [N-1:0] d, input logic m, input logic e);
    valid     = v;
    data      = d;
    msb_first = m;
    shift_en  = e;
    #1;
    obs  = dut_out();
    expv = model_out();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    valid = 1'b1;
    data  = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    obs = dut_out();
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL reset_hold: outputs got %b want %b", obs, 6'b000000);
    end
    @(posedge clk);
    #2;
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    obs = dut_out();
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL reset_release: outputs got %b want %b", obs, 6'b100000);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_word(input string name, input logic [N-1:0] d, input logic m,
                           input logic [7:0] seq);
    logic [5:0] want;
    cycle(1'b1, d, m, 1'b1);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s_accept: got %b want %b", name, obs, expv);
    end
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      want = {i == 7, 1'b1, 1'b1, seq[7-i], i == 0, i == 7};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL %s_bit%0d: got %b want %b", name, i, obs, want);
      end
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s_model%0d: got %b want %b", name, i, obs, expv);
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL %s_idle: got %b want %b", name, obs, 6'b100000);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    logic [5:0]  want;
    bit          lst;
    seq = 16'b1100_0100_1000_0001;
    cycle(1'b1, 8'hC4, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cycle(i < 8, 8'h81, 1'b1, 1'b1);
      lst  = (i == 7) || (i == 15);
      want = {lst, 1'b1, 1'b1, seq[15-i], (i == 0) || (i == 8), lst};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL b2b_bit%0d: got %b want %b", i, obs, want);
      end
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL b2b_model%0d: got %b want %b", i, obs, expv);
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL b2b_idle: got %b want %b", obs, 6'b100000);
    end
  endtask

  task automatic test_stall();
    int         j = 0;
    int         vcyc = 0;
    int         dis = 0;
    int         nbits = 0;
    logic [7:0] got = '0;
    logic       en;
    cycle(1'b1, 8'hC4, 1'b1, 1'b1);
    while (j < 40) begin
      en = (j % 4 == 0) || (j % 4 == 3);
      cycle(1'b0, '0, 1'b0, en);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL stall_model%0d: got %b want %b", j, obs, expv);
      end
      if (!obs[4]) break;
      vcyc++;
      if (!en) dis++;
      else begin
        got = {got[6:0], obs[2]};
        nbits++;
      end
      j++;
    end
    checks++;
    if (j >= 40) begin
      errors++;
      $display("FAIL stall_timeout: svalid still high after %0d cycles", j);
    end
    checks++;
    if (vcyc != 8 + dis) begin
      errors++;
      $display("FAIL stall_length: valid cycles %0d want %0d", vcyc, 8 + dis);
    end
    checks++;
    if (got !== 8'hC4 || nbits != 8) begin
      errors++;
      $display("FAIL stall_order: bits %h (%0d) want c4 (8)", got, nbits);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] seq;
    logic [5:0] want;
    seq = 8'h81;
    cycle(1'b1, 8'hC4, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    obs = dut_out();
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL midreset_async: got %b want %b", obs, 6'b000000);
    end
    m_busy = 1'b0;
    m_pos  = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    obs = dut_out();
    checks++;
    if (obs !== 6'b100000) begin
      errors++;
      $display("FAIL midreset_release: got %b want %b", obs, 6'b100000);
    end
    cycle(1'b1, 8'h81, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      want = {i == 7, 1'b1, 1'b1, seq[7-i], i == 0, i == 7};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL midreset_bit%0d: got %b want %b", i, obs, want);
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic         v = 1'b0;
    logic [N-1:0] d = '0;
    logic         m = 1'b0;
    logic         e;
    bit           pend = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!pend) begin
        v = ($urandom_range(0, 2) != 0);
        d = N'($urandom);
        m = 1'($urandom);
      end
      e = ($urandom_range(0, 3) != 0);
      cycle(v, d, m, e);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL random_cyc%0d: got %b want %b", c, obs, expv);
      end
      pend = v && !m_acc;
    end
  endtask

  initial begin
    test_reset();
    test_word("msb", 8'hC4, 1'b1, 8'b1100_0100);
    test_word("lsb", 8'hC4, 1'b0, 8'b0010_0011);
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
